method_call_sequencer: RTL

// - Synthesisable, parametrised driver for the req/busy/return method handshake of generated HLS modules.
// - Calls up to N_CH methods one at a time, in index order, after a start-up holdoff.
// - Each call has a timeout. The block compares every return value with an expected value and reports pass/fail and per-channel masks.
// - Used inside self-checking sim benches and on-board smoke tests. It replaces ad-hoc per-test counter logic.

---
 rtl/sim_harness_pkg.sv | 13 +
 rtl/call_timer.sv | 18 +
 rtl/method_call_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sim_harness_pkg.sv
// sim_harness_pkg: FSM encoding, return-slice helper and result constants shared by
// the method-call sequencer and the benches that drive it.
`ifndef SIM_HARNESS_PKG_SV
`define SIM_HARNESS_PKG_SV
`define RET_SLICE(v, i) v[(i)*RET_W +: RET_W]
package sim_harness_pkg;
    typedef enum logic [2:0] {
        ST_IDLE, ST_HOLDOFF, ST_SELECT, ST_REQ, ST_RUN, ST_CHECK, ST_DONE
    } state_e;
    localparam logic RESULT_PASS = 1'b1;
    localparam logic RESULT_FAIL = 1'b0;
endpackage
`endif

// File: rtl/call_timer.sv
// call_timer: clearable up-counter that saturates at limit and flags when it sits there.
module call_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign term = (cnt_q == limit);
    assign cnt  = cnt_q;
    always_comb cnt_d = clr ? '0 : (en && !term) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/method_call_sequencer.sv
// method_call_sequencer: calls enabled req/busy/return methods in index order after a
// holdoff, with a per-call timeout, and reports per-channel fail/timeout masks.
module method_call_sequencer
    import sim_harness_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int RET_W   = 32,
    parameter int HOLDOFF = 100,
    parameter int TIMEOUT = 100000,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N_CH-1:0]           ch_enable,
    input  logic [N_CH-1:0]           ch_busy,
    input  logic [N_CH*RET_W-1:0]     ch_return,
    input  logic [N_CH*RET_W-1:0]     ch_expect,
    output logic [N_CH-1:0]           ch_req,
    output logic [$clog2(N_CH):0]     cur_ch,
    output logic                      done,
    output logic                      pass,
    output logic [N_CH-1:0]           fail_mask,
    output logic [N_CH-1:0]           timeout_mask,
    output logic [CNT_W-1:0]          last_cycles
);
    localparam int CH_W = $clog2(N_CH) + 1;
    // The timer flags on the cycle it holds limit, so limits are one below the counts.
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLDOFF > 0 ? HOLDOFF - 1 : 0);
    localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [N_CH-1:0]   ch_req_q, ch_req_d;
    logic [N_CH-1:0]   fail_mask_q, fail_mask_d;
    logic [N_CH-1:0]   timeout_mask_q, timeout_mask_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic              done_q, done_d, pass_q, pass_d;
    logic [CNT_W-1:0]  last_cycles_q, last_cycles_d, cnt;
    logic              term, timing;
    logic [N_CH-1:0]   sel;
    logic [RET_W-1:0]  ret_sel, exp_sel;

    assign sel    = N_CH'(1) << cur_ch_q;
    assign timing = state_q inside {ST_HOLDOFF, ST_REQ, ST_RUN};

    call_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (!timing),
        .en    (timing),
        .limit (state_q == ST_HOLDOFF ? HOLD_LIM : TMO_LIM),
        .cnt   (cnt),
        .term  (term)
    );

    always_comb begin
        ret_sel = '0;
        exp_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel[i]) begin
                ret_sel = `RET_SLICE(ch_return, i);
                exp_sel = `RET_SLICE(ch_expect, i);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ch_req_d       = ch_req_q;
        cur_ch_d       = cur_ch_q;
        done_d         = done_q;
        pass_d         = pass_q;
        fail_mask_d    = fail_mask_q;
        timeout_mask_d = timeout_mask_q;
        last_cycles_d  = last_cycles_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d        = HOLDOFF == 0 ? ST_SELECT : ST_HOLDOFF;
                    cur_ch_d       = '0;
                    done_d         = 1'b0;
                    pass_d         = 1'b0;
                    fail_mask_d    = '0;
                    timeout_mask_d = '0;
                end
            end
            ST_HOLDOFF: begin
                if (term) begin
                    state_d  = ST_SELECT;
                    cur_ch_d = '0;
                end
            end
            ST_SELECT: begin
                if (cur_ch_q == CH_W'(N_CH)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = ~|(fail_mask_q | timeout_mask_q) ? RESULT_PASS : RESULT_FAIL;
                end else if (~|(ch_enable & sel)) begin
                    cur_ch_d = cur_ch_q + 1'b1;
                end else begin
                    state_d  = ST_REQ;
                    ch_req_d = sel;
                end
            end
            ST_REQ, ST_RUN: begin
                // Timeout wins over a same-cycle ack or completion.
                if (term) begin
                    state_d        = ST_SELECT;
                    ch_req_d       = '0;
                    timeout_mask_d = timeout_mask_q | sel;
                    cur_ch_d       = cur_ch_q + 1'b1;
                end else if (state_q == ST_REQ && |(ch_busy & sel)) begin
                    state_d  = ST_RUN;
                    ch_req_d = '0;
                end else if (state_q == ST_RUN && ~|(ch_busy & sel)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (ret_sel != exp_sel) fail_mask_d = fail_mask_q | sel;
                last_cycles_d = cnt;
                cur_ch_d      = cur_ch_q + 1'b1;
                state_d       = ST_SELECT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            ch_req_q       <= '0;
            cur_ch_q       <= '0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            fail_mask_q    <= '0;
            timeout_mask_q <= '0;
            last_cycles_q  <= '0;
        end else begin
            state_q        <= state_d;
            ch_req_q       <= ch_req_d;
            cur_ch_q       <= cur_ch_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            fail_mask_q    <= fail_mask_d;
            timeout_mask_q <= timeout_mask_d;
            last_cycles_q  <= last_cycles_d;
        end
    end

    assign ch_req       = ch_req_q;
    assign cur_ch       = cur_ch_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign fail_mask    = fail_mask_q;
    assign timeout_mask = timeout_mask_q;
    assign last_cycles  = last_cycles_q;
endmodule
